usb_data_buffer: RTL and testbench

Shared 64-byte FIFO that sits directly upstream of the USB transmitter and directly downstream of the USB receiver. It holds bytes written by the host-side bus slave for transmission and bytes captured by the receiver for host readout. It presents `tx_packet_data` and `buffer_occupancy` to the transmitter, which pops one byte per `get_tx_packet_data` strobe.

---
 rtl/usb_data_buffer.sv | 133 +++++++++++++
 tb/tb_usb_data_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between the host bus slave and the USB transmitter/receiver.
// First-word fall-through head, up to 4-byte host transfers, single-byte USB side.
module usb_data_buffer #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     clear,
   input  logic                     store_tx_data,
   input  logic [31:0]              tx_data,
   input  logic [1:0]               data_size,
   input  logic                     get_rx_data,
   output logic [31:0]              rx_data,
   input  logic                     store_rx_packet_data,
   input  logic [7:0]               rx_packet_data,
   input  logic                     get_tx_packet_data,
   output logic [7:0]               tx_packet_data,
   output logic [$clog2(DEPTH):0]   buffer_occupancy,
   output logic                     buffer_overflow,
   output logic                     buffer_underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr_reg, wptr_next;
   logic [AW-1:0] rptr_reg, rptr_next;
   logic [AW:0]   occ_reg, occ_next;
   logic          overflow_reg, overflow_next;
   logic          underflow_reg, underflow_next;

   logic [2:0]    host_n;
   logic          host_ok;
   logic          wr_req, wr_from_host, wr_collide, wr_legal;
   logic          rd_req, rd_legal;
   logic [2:0]    wr_n, rd_n, push_n, pop_n;
   logic [7:0]    wr_byte [4];

   always_comb begin
      host_n = 3'd0;
      case (data_size)
         2'd0:    host_n = 3'd1;
         2'd1:    host_n = 3'd2;
         2'd2:    host_n = 3'd4;
         default: host_n = 3'd0;
      endcase
      host_ok = (data_size != 2'd3);

      wr_req       = 1'b0;
      wr_from_host = 1'b0;
      wr_collide   = 1'b0;
      wr_n         = 3'd0;
      rd_req       = 1'b0;
      rd_n         = 3'd0;
      // A size-3 host strobe counts as absent, so it neither wins arbitration nor errors.
      if (!clear) begin
         if (store_tx_data && host_ok) begin
            wr_req       = 1'b1;
            wr_from_host = 1'b1;
            wr_n         = host_n;
            wr_collide   = store_rx_packet_data;
         end else if (store_rx_packet_data) begin
            wr_req = 1'b1;
            wr_n   = 3'd1;
         end
         if (get_rx_data && host_ok) begin
            rd_req = 1'b1;
            rd_n   = host_n;
         end else if (get_tx_packet_data) begin
            rd_req = 1'b1;
            rd_n   = 3'd1;
         end
      end

      // Both checks use occupancy before any same-cycle pop.
      wr_legal = ({1'b0, occ_reg} + (AW+2)'(wr_n)) <= (AW+2)'(DEPTH);
      rd_legal = occ_reg >= (AW+1)'(rd_n);
      push_n   = (wr_req && wr_legal) ? wr_n : 3'd0;
      pop_n    = (rd_req && rd_legal) ? rd_n : 3'd0;

      wptr_next      = wptr_reg + AW'(push_n);
      rptr_next      = rptr_reg + AW'(pop_n);
      occ_next       = occ_reg + (AW+1)'(push_n) - (AW+1)'(pop_n);
      overflow_next  = wr_collide || (wr_req && !wr_legal);
      underflow_next = rd_req && !rd_legal;

      if (clear) begin
         wptr_next = '0;
         rptr_next = '0;
         occ_next  = '0;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign wr_byte[gi] = wr_from_host ? tx_data[8*gi +: 8]
                                           : ((gi == 0) ? rx_packet_data : 8'h00);
         assign rx_data[8*gi +: 8] = ((3'(gi) < host_n) && ((AW+1)'(gi) < occ_reg))
                                     ? mem[rptr_reg + AW'(gi)] : 8'h00;
      end
   endgenerate

   // Pointer arithmetic wraps naturally, so multi-byte writes straddle the top index.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < push_n) begin
            mem[wptr_reg + AW'(k)] <= wr_byte[k];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         occ_reg       <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wptr_reg      <= wptr_next;
         rptr_reg      <= rptr_next;
         occ_reg       <= occ_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign tx_packet_data   = (occ_reg == '0) ? 8'h00 : mem[rptr_reg];
   assign buffer_occupancy = occ_reg;
   assign buffer_overflow  = overflow_reg;
   assign buffer_underflow = underflow_reg;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scoreboard bench for usb_data_buffer: a byte-queue model predicts every head,
// popped value, occupancy and error pulse.
module tb_usb_data_buffer;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        clear;
   logic        store_tx_data;
   logic [31:0] tx_data;
   logic [1:0]  data_size;
   logic        get_rx_data;
   logic [31:0] rx_data;
   logic        store_rx_packet_data;
   logic [7:0]  rx_packet_data;
   logic        get_tx_packet_data;
   logic [7:0]  tx_packet_data;
   logic [6:0]  buffer_occupancy;
   logic        buffer_overflow;
   logic        buffer_underflow;

   int total = 0;
   int bad   = 0;

   logic [7:0]  mdl_q [$];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   usb_data_buffer #(.DEPTH(64)) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .clear                (clear),
      .store_tx_data        (store_tx_data),
      .tx_data              (tx_data),
      .data_size            (data_size),
      .get_rx_data          (get_rx_data),
      .rx_data              (rx_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet_data       (rx_packet_data),
      .get_tx_packet_data   (get_tx_packet_data),
      .tx_packet_data       (tx_packet_data),
      .buffer_occupancy     (buffer_occupancy),
      .buffer_overflow      (buffer_overflow),
      .buffer_underflow     (buffer_underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int size_n(input logic [1:0] sz);
      case (sz)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   // Host-read view of the model: lane k holds queue entry k when k < n and k < occupancy.
   function automatic logic [31:0] lanes(input logic [1:0] sz);
      logic [31:0] v;
      v = 32'h0;
      for (int k = 0; k < 4; k++)
         if (k < size_n(sz) && k < mdl_q.size()) v[8*k +: 8] = mdl_q[k];
      return v;
   endfunction

   task automatic idle_inputs();
      clear = 0; store_tx_data = 0; tx_data = 0; data_size = 0;
      get_rx_data = 0; store_rx_packet_data = 0; rx_packet_data = 0; get_tx_packet_data = 0;
   endtask

   task automatic step(input logic clr, input logic s_tx, input logic [31:0] d,
                       input logic [1:0] sz, input logic g_rx, input logic s_rx,
                       input logic [7:0] rb, input logic g_tx);
      int          occ, n, wn, rn;
      logic        wreq, wlegal, wtx, rreq, rlegal, rrx, ovf, udf;
      logic [31:0] popped, got;
      clear = clr; store_tx_data = s_tx; tx_data = d; data_size = sz;
      get_rx_data = g_rx; store_rx_packet_data = s_rx; rx_packet_data = rb;
      get_tx_packet_data = g_tx;
      #1;
      occ = mdl_q.size();
      check("head", {24'h0, tx_packet_data}, (occ != 0) ? {24'h0, mdl_q[0]} : 32'h0);
      check("rx_lanes", rx_data, lanes(sz));

      n = size_n(sz);
      wreq = 0; wtx = 0; wn = 0; rreq = 0; rrx = 0; rn = 0; ovf = 0; udf = 0;
      if (!clr) begin
         if (s_tx && sz != 2'd3) begin
            wreq = 1; wtx = 1; wn = n; ovf = s_rx;
         end else if (s_rx) begin
            wreq = 1; wn = 1;
         end
         if (g_rx && sz != 2'd3) begin
            rreq = 1; rrx = 1; rn = n;
         end else if (g_tx) begin
            rreq = 1; rn = 1;
         end
      end
      wlegal = wreq && (occ + wn <= 64);
      rlegal = rreq && (occ >= rn);
      if (wreq && !wlegal) ovf = 1;
      if (rreq && !rlegal) udf = 1;

      if (rlegal) begin
         popped = rrx ? lanes(sz) : {24'h0, mdl_q[0]};
         exp_q.push_back(popped);
         got = rrx ? rx_data : {24'h0, tx_packet_data};
         check(rrx ? "host_read" : "tx_pop", got, exp_q.pop_front());
         for (int k = 0; k < rn; k++) void'(mdl_q.pop_front());
      end
      if (wlegal)
         for (int k = 0; k < wn; k++) mdl_q.push_back(wtx ? d[8*k +: 8] : rb);
      if (clr) mdl_q.delete();

      @(posedge clk);
      #1;
      idle_inputs();
      check("occupancy", {25'h0, buffer_occupancy}, mdl_q.size());
      check("overflow", {31'h0, buffer_overflow}, {31'h0, ovf});
      check("underflow", {31'h0, buffer_underflow}, {31'h0, udf});
      $display("txn t=%0t clr=%0d stx=%0d sz=%0d grx=%0d srx=%0d gtx=%0d occ=%0d ovf=%0d udf=%0d",
               $time, clr, s_tx, sz, g_rx, s_rx, g_tx, buffer_occupancy, buffer_overflow,
               buffer_underflow);
   endtask

   task automatic push_rx(input logic [7:0] b);
      step(0, 0, 0, 0, 0, 1, b, 0);
   endtask

   task automatic pop_tx();
      step(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      idle_inputs();
      n_rst = 0;
      #12;
      check("rst_occ", {25'h0, buffer_occupancy}, 32'h0);
      check("rst_head", {24'h0, tx_packet_data}, 32'h0);
      check("rst_rx", rx_data, 32'h0);
      check("rst_ovf", {31'h0, buffer_overflow}, 32'h0);
      check("rst_udf", {31'h0, buffer_underflow}, 32'h0);
      @(negedge clk);
      n_rst = 1;
      @(posedge clk);
      #1;
      idle();
      idle();

      // 4-byte host write, drained one byte at a time by the transmitter
      step(0, 1, 32'h44332211, 2'd2, 0, 0, 0, 0);
      repeat (4) pop_tx();
      pop_tx();

      // fill to 62, reject a 4-byte write, accept a 2-byte write to reach full
      for (int i = 0; i < 62; i++) push_rx(8'(i * 3 + 1));
      step(0, 1, 32'hA1A2A3A4, 2'd2, 0, 0, 0, 0);
      step(0, 1, 32'h0000B2B1, 2'd1, 0, 0, 0, 0);
      push_rx(8'hEE);
      step(0, 0, 0, 2'd0, 0, 0, 0, 1);
      step(0, 1, 32'h000000C7, 2'd0, 0, 0, 0, 0);
      repeat (16) step(0, 0, 0, 2'd2, 1, 0, 0, 0);
      step(0, 0, 0, 2'd2, 1, 0, 0, 0);

      // walk pointers to 62 then do a wrapping 4-byte write and read
      while (dut.rptr_reg != 6'd62 && total < 5000) begin
         push_rx(8'h33);
         pop_tx();
      end
      check("ptr_at_62", {26'h0, dut.rptr_reg}, 32'd62);
      step(0, 1, 32'hDDCCBBAA, 2'd2, 0, 0, 0, 0);
      step(0, 0, 0, 2'd2, 1, 0, 0, 0);

      // simultaneous receiver push and transmitter pop at occupancy 1
      push_rx(8'h77);
      step(0, 0, 0, 0, 0, 1, 8'h5A, 1);
      idle();
      pop_tx();

      // clear beats a same-cycle host write
      for (int i = 0; i < 10; i++) push_rx(8'(8'h80 + i));
      step(1, 1, 32'h12345678, 2'd2, 0, 0, 0, 0);
      idle();

      // size 3 is ignored; write and read collisions
      step(0, 1, 32'hFFFFFFFF, 2'd3, 0, 0, 0, 0);
      step(0, 0, 0, 2'd3, 1, 0, 0, 0);
      step(0, 1, 32'h00006655, 2'd1, 0, 1, 8'h99, 0);
      step(0, 0, 0, 2'd0, 1, 0, 0, 1);
      step(0, 1, 32'h0000DEAD, 2'd3, 0, 1, 8'h42, 0);

      // random traffic
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), $urandom,
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 2) == 0));

      // asynchronous reset in the middle of a cycle discards everything
      for (int i = 0; i < 5; i++) push_rx(8'(8'h10 + i));
      #2;
      n_rst = 0;
      #1;
      mdl_q.delete();
      check("arst_occ", {25'h0, buffer_occupancy}, 32'h0);
      check("arst_head", {24'h0, tx_packet_data}, 32'h0);
      @(posedge clk);
      #1;
      n_rst = 1;
      idle();
      push_rx(8'h3C);
      pop_tx();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL timeout got=running exp=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
